whizgraphics_line_renderer: RTL and testbench

//  Parametrised next-generation background renderer: on each drawline pulse, renders one scanline from tile map + tile data RAMs.

---
 rtl/whizgraphics_line_renderer_pkg.sv | 21 ++
 rtl/whizgraphics_tile_shifter.sv | 52 +++++
 rtl/whizgraphics_line_renderer.sv | 148 ++++++++++++++
 tb/tb_whizgraphics_line_renderer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/whizgraphics_line_renderer_pkg.sv
// Shared types and default geometry for the WhizGraphics background line renderer.
package video_types;

    localparam int DEF_LCD_W  = 160;
    localparam int DEF_LCD_H  = 144;
    localparam int DEF_TILE_W = 8;
    localparam int DEF_BPP    = 2;

    // One row of a tile at default geometry: plane p lives at [p*TILE_W +: TILE_W].
    typedef logic [DEF_TILE_W*DEF_BPP-1:0] tile_row_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAP   = 3'd1,
        ST_TILE  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } render_state_e;

endpackage

// File: rtl/whizgraphics_tile_shifter.sv
// Planar tile-row shifter: loads one row, drops a leading skip count, then
// presents one colour index per shift with the leftmost pixel first.
module whizgraphics_tile_shifter
    import video_types::*;
#(
    parameter int TILE_W = DEF_TILE_W,
    parameter int BPP    = DEF_BPP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [$clog2(TILE_W)-1:0] skip,
    input  logic [TILE_W*BPP-1:0]     row,
    input  logic                      shift,
    output logic [BPP-1:0]            idx,
    output logic                      last,
    output logic                      empty
);

    localparam int CW = $clog2(TILE_W) + 1;

    logic [BPP-1:0][TILE_W-1:0] plane_q;
    logic [CW-1:0]              count_q;

    always_ff @(posedge clk) begin
        // NOTE: the datapath is cleared on reset too, so an abandoned line leaves no stale pixels behind.
        if (!rst_n) begin
            plane_q <= '0;
            count_q <= '0;
        end else if (load) begin
            // Skipped pixels are shifted out at load time so the first visible one is ready at once.
            for (int p = 0; p < BPP; p++)
                plane_q[p] <= row[p*TILE_W +: TILE_W] << skip;
            count_q <= CW'(TILE_W) - CW'(skip);
        end else if (shift && !empty) begin
            for (int p = 0; p < BPP; p++)
                plane_q[p] <= plane_q[p] << 1;
            count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        idx = '0;
        for (int p = 0; p < BPP; p++)
            idx[p] = plane_q[p][TILE_W-1];
    end

    assign last  = (count_q == CW'(1));
    assign empty = (count_q == '0);

endmodule

// File: rtl/whizgraphics_line_renderer.sv
// Background scanline renderer: fetches map/tile rows and streams pixels over valid/ready.
// Build option: define WHIZ_RENDER_PALETTE_EN to add a per-line palette input.
module whizgraphics_line_renderer
    import video_types::*;
#(
    parameter int LCD_W     = DEF_LCD_W,
    parameter int LCD_H     = DEF_LCD_H,
    parameter int TILE_W    = DEF_TILE_W,
    parameter int BPP       = DEF_BPP,
    parameter int MAP_TILES = 32,
    parameter int TILE_CNT  = 256
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          drawline,
    input  logic [7:0]                                    scx,
    input  logic [7:0]                                    scy,
    output logic [$clog2(MAP_TILES*MAP_TILES)-1:0]        map_addr,
    input  logic [$clog2(TILE_CNT)-1:0]                   map_data,
    output logic [$clog2(TILE_CNT)+$clog2(TILE_W)-1:0]    tile_addr,
    input  logic [TILE_W*BPP-1:0]                         tile_data,
    output logic                                          pix_valid,
    input  logic                                          pix_ready,
`ifdef WHIZ_RENDER_PALETTE_EN
    input  logic [(2**BPP)*BPP-1:0]                       palette,
`endif
    output logic [BPP-1:0]                                pix_data,
    output logic [$clog2(LCD_W)-1:0]                      pix_x,
    output logic [$clog2(LCD_H)-1:0]                      pix_y,
    output logic                                          line_done,
    output logic                                          render_complete,
    output logic                                          busy
);

    localparam int TSH = $clog2(TILE_W);
    localparam int MTW = $clog2(MAP_TILES);
    localparam int MAW = $clog2(MAP_TILES*MAP_TILES);
    localparam int SW  = TSH + MTW;
    localparam int PXW = $clog2(LCD_W);
    localparam int LYW = $clog2(LCD_H);
    localparam logic [PXW-1:0] PX_LAST = PXW'(LCD_W - 1);
    localparam logic [LYW-1:0] LY_LAST = LYW'(LCD_H - 1);

    render_state_e  state_q;
    logic [7:0]     scx_q, scy_q;
    logic [PXW-1:0] px_q;
    logic [LYW-1:0] ly_q;
    logic           first_q, rc_q;
    logic [SW-1:0]  y_sum;
    logic [MTW-1:0] tile_x;
    logic [BPP-1:0] idx, color;
    logic           sh_last, sh_empty, start, accept;

    // Map-space coordinates wrap at MAP_TILES*TILE_W simply by truncating to SW bits.
    assign y_sum  = SW'(ly_q) + SW'(scy_q);
    assign tile_x = MTW'((SW'(px_q) + SW'(scx_q)) >> TSH);

    assign start  = (state_q == ST_IDLE) && drawline;
    assign accept = pix_valid && pix_ready;

    assign map_addr  = (state_q == ST_MAP)  ? MAW'({y_sum[SW-1:TSH], tile_x}) : '0;
    assign tile_addr = (state_q == ST_TILE) ? {map_data, y_sum[TSH-1:0]} : '0;

    whizgraphics_tile_shifter #(
        .TILE_W (TILE_W),
        .BPP    (BPP)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q == ST_LOAD),
        .skip  (first_q ? scx_q[TSH-1:0] : '0),
        .row   (tile_data),
        .shift (accept),
        .idx   (idx),
        .last  (sh_last),
        .empty (sh_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            scx_q   <= '0;
            scy_q   <= '0;
            px_q    <= '0;
            ly_q    <= '0;
            first_q <= 1'b0;
            rc_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (drawline) begin
                    state_q <= ST_MAP;
                    scx_q   <= scx;
                    scy_q   <= scy;
                    px_q    <= '0;
                    first_q <= 1'b1;
                    rc_q    <= 1'b0;
                end
                ST_MAP:  state_q <= ST_TILE;
                ST_TILE: state_q <= ST_LOAD;
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                    first_q <= 1'b0;
                end
                ST_SHIFT: if (accept) begin
                    if (px_q == PX_LAST) begin
                        state_q <= ST_DONE;
                        if (ly_q == LY_LAST) begin
                            ly_q <= '0;
                            rc_q <= 1'b1;
                        end else begin
                            ly_q <= ly_q + 1'b1;
                        end
                    end else begin
                        px_q <= px_q + 1'b1;
                        if (sh_last)
                            state_q <= ST_MAP;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef WHIZ_RENDER_PALETTE_EN
    logic [(2**BPP)*BPP-1:0] palette_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            palette_q <= '0;
        else if (start)
            palette_q <= palette;
    end

    assign color = palette_q[idx*BPP +: BPP];
`else
    assign color = idx;
`endif

    assign pix_valid       = (state_q == ST_SHIFT) && !sh_empty;
    assign pix_data        = pix_valid ? color : '0;
    assign pix_x           = px_q;
    assign pix_y           = ly_q;
    assign line_done       = (state_q == ST_DONE);
    assign render_complete = rc_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_whizgraphics_line_renderer.sv
// Self-checking bench for whizgraphics_line_renderer against a pixel-level reference model.
module tb_whizgraphics_line_renderer;

    localparam int LCD_W     = 160;
    localparam int LCD_H     = 144;
    localparam int TILE_W    = 8;
    localparam int MAP_TILES = 32;
    localparam int TILE_CNT  = 256;
    localparam int WRAP      = MAP_TILES * TILE_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drawline = 1'b0;
    logic        pix_ready = 1'b0;
    logic [7:0]  scx = '0;
    logic [7:0]  scy = '0;
    logic [9:0]  map_addr;
    logic [7:0]  map_data;
    logic [10:0] tile_addr;
    logic [15:0] tile_data;
    logic        pix_valid;
    logic [1:0]  pix_data;
    logic [7:0]  pix_x, pix_y;
    logic        line_done, render_complete, busy;
`ifdef WHIZ_RENDER_PALETTE_EN
    logic [7:0]  palette = 8'hE4;
`endif

    logic [7:0]  map_mem  [MAP_TILES*MAP_TILES];
    logic [15:0] tile_mem [TILE_CNT*TILE_W];

    int checks = 0;
    int errors = 0;
    int exp_ly = 0;
    int ld_count = 0;

    whizgraphics_line_renderer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .drawline        (drawline),
        .scx             (scx),
        .scy             (scy),
        .map_addr        (map_addr),
        .map_data        (map_data),
        .tile_addr       (tile_addr),
        .tile_data       (tile_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
`ifdef WHIZ_RENDER_PALETTE_EN
        .palette         (palette),
`endif
        .pix_data        (pix_data),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .line_done       (line_done),
        .render_complete (render_complete),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs with one cycle of read latency.
    always @(posedge clk) begin
        map_data  <= map_mem[map_addr];
        tile_data <= tile_mem[tile_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Screen pixel x of line ly, straight from the scroll/wrap/tile rules.
    function automatic logic [1:0] ref_pixel(input int x, input int sx, input int sy, input int ly);
        int gx, gy, b, t;
        logic [15:0] w;
        logic [1:0]  c;
        gx = (x + sx) % WRAP;
        gy = (ly + sy) % WRAP;
        t  = int'(map_mem[(gy / TILE_W) * MAP_TILES + gx / TILE_W]);
        w  = tile_mem[t * TILE_W + gy % TILE_W];
        b  = TILE_W - 1 - gx % TILE_W;
        c  = {w[TILE_W + b], w[b]};
`ifdef WHIZ_RENDER_PALETTE_EN
        c  = palette[c*2 +: 2];
`endif
        return c;
    endfunction

    task automatic render_line(input int sx, input int sy, input bit stalls, input bit poke);
        logic [1:0] exp_pix [LCD_W];
        int k, c, first_at, gy, emap, etile, old_ly;
        bit done_seen, held;
        logic [1:0] hd;
        logic [7:0] hx;
        old_ly = exp_ly;
        for (int x = 0; x < LCD_W; x++)
            exp_pix[x] = ref_pixel(x, sx, sy, old_ly);
        gy    = (old_ly + sy) % WRAP;
        emap  = (gy / TILE_W) * MAP_TILES + (sx % WRAP) / TILE_W;
        etile = int'(map_mem[emap]) * TILE_W + gy % TILE_W;

        drawline = 1'b1;
        scx = 8'(sx);
        scy = 8'(sy);
        @(negedge clk);
        drawline = 1'b0;
        scx = 8'($urandom);
        scy = 8'($urandom);
        k = 0; c = 1; first_at = -1; done_seen = 0; held = 0;
        while (!done_seen && c < 4000) begin
            if (c == 1) begin
                check("busy_after_accept", busy, 1);
                check("rc_cleared", render_complete, 0);
                check("map_addr", map_addr, emap);
            end
            if (c == 2)
                check("tile_addr", tile_addr, etile);
            if (held) begin
                check("stall_valid", pix_valid, 1);
                check("stall_data", pix_data, hd);
                check("stall_x", pix_x, hx);
                held = 0;
            end
            if (pix_valid && first_at < 0)
                first_at = c;
            if (line_done) begin
                done_seen = 1;
                ld_count++;
                check("pix_count", k, LCD_W);
                check("ly_after_line", pix_y, (old_ly + 1) % LCD_H);
                check("rc_at_done", render_complete, old_ly == LCD_H - 1);
            end else begin
                pix_ready = stalls ? ($urandom_range(2) != 0) : 1'b1;
                drawline  = poke && (c == 60);
                if (pix_valid && pix_ready) begin
                    if (k < LCD_W)
                        check("pix_data", pix_data, exp_pix[k]);
                    else
                        check("pix_overrun", k, LCD_W - 1);
                    check("pix_x", pix_x, k);
                    check("pix_y", pix_y, old_ly);
                    k++;
                end else if (pix_valid) begin
                    held = 1;
                    hd = pix_data;
                    hx = pix_x;
                end
                @(negedge clk);
                c++;
            end
        end
        drawline = 1'b0;
        check("line_done_seen", done_seen, 1);
        check("first_valid_cycle", first_at, 4);
        exp_ly = (old_ly + 1) % LCD_H;
        @(negedge clk);
        check("idle_after_done", busy, 0);
        check("line_done_pulse", line_done, 0);
        if (poke) begin
            repeat (3) @(negedge clk);
            check("drawline_busy_ignored", busy, 0);
        end
    endtask

    initial begin
        int c;
        for (int i = 0; i < MAP_TILES*MAP_TILES; i++) map_mem[i] = 8'h00;
        for (int i = 0; i < TILE_CNT*TILE_W; i++) tile_mem[i] = 16'($urandom);
        // Tile 0 checkerboard (colour 3 at even pixels of even rows), tile 1 ramp 0,1,2,3.
        for (int r = 0; r < TILE_W; r++) begin
            tile_mem[r]          = (r % 2 == 0) ? 16'hAAAA : 16'h0000;
            tile_mem[TILE_W + r] = 16'h3355;
        end

        repeat (3) @(negedge clk);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_line_done", line_done, 0);
        check("rst_render_complete", render_complete, 0);
        check("rst_map_addr", map_addr, 0);
        check("rst_tile_addr", tile_addr, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        rst_n = 1'b1;
        @(negedge clk);

        render_line(0, 0, 0, 0);
        for (int i = 0; i < MAP_TILES*MAP_TILES; i++) map_mem[i] = 8'h01;
        render_line(3, 0, 0, 0);

        for (int i = 0; i < MAP_TILES*MAP_TILES; i++) map_mem[i] = 8'($urandom);
        for (int l = 2; l < 10; l++)
            render_line((l == 2) ? 255 : int'($urandom_range(255)), int'($urandom_range(255)), l % 2 == 1, 0);
        render_line(int'($urandom_range(255)), 250, 0, 0);
        for (int l = 11; l < 15; l++)
            render_line(int'($urandom_range(255)), int'($urandom_range(255)), 1, 0);
        render_line(int'($urandom_range(255)), int'($urandom_range(255)), 0, 1);
        for (int l = 16; l < LCD_H; l++)
            render_line(int'($urandom_range(255)), int'($urandom_range(255)), 0, 0);

        check("frame_line_done_count", ld_count, LCD_H);
        repeat (5) @(negedge clk);
        check("rc_held_idle", render_complete, 1);

        render_line(int'($urandom_range(255)), int'($urandom_range(255)), 0, 0);
        render_line(int'($urandom_range(255)), int'($urandom_range(255)), 1, 0);

        // Abandon a line mid-stream with reset.
        pix_ready = 1'b1;
        drawline  = 1'b1;
        @(negedge clk);
        drawline = 1'b0;
        c = 0;
        while (!pix_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("mid_line_valid", pix_valid, 1);
        repeat (10) @(negedge clk);
        check("mid_line_pix_y", pix_y, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_line_done", line_done, 0);
        check("midrst_pix_y", pix_y, 0);
        rst_n = 1'b1;
        exp_ly = 0;
        @(negedge clk);
        render_line(int'($urandom_range(255)), int'($urandom_range(255)), 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
